// File: rtl/rr_arb_pkg.sv
// Shared constants and types for the 4-channel round-robin arbiter.
package rr_arb_pkg;
  localparam int N_CH  = 4;
  localparam int SEL_W = 2;
  localparam int CNT_W = 8;

  typedef logic [SEL_W-1:0] sel_t;
endpackage : rr_arb_pkg

// File: rtl/rr_arb_4_1_if.sv
// Request/response bundle for rr_arb_4_1: four valid/ready input channels and one registered output.
// Handshake: a word moves when valid && ready in the same cycle; valid never waits on ready.
interface rr_arb_4_1_if
  import rr_arb_pkg::*;
#(
  parameter int W = 4
);
  logic [N_CH-1:0]   in_valid;
  logic [N_CH*W-1:0] in_data;
  logic [N_CH-1:0]   in_ready;
  logic              out_valid;
  logic [W-1:0]      out_data;
  sel_t              out_sel;
  logic              out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );
endinterface : rr_arb_4_1_if

// File: rtl/mux_4_1.sv
// Plain 4:1 mux of 4-bit words; sel=2'b10 picks d2.
module mux_4_1 (
  input  logic [3:0] d0,
  input  logic [3:0] d1,
  input  logic [3:0] d2,
  input  logic [3:0] d3,
  input  logic [1:0] sel,
  output logic [3:0] y
);
  always_comb begin
    y = d0;
    case (sel)
      2'b00: y = d0;
      2'b01: y = d1;
      2'b10: y = d2;
      2'b11: y = d3;
      default: y = d0;
    endcase
  end
endmodule : mux_4_1

// File: rtl/rr_arb_4_1.sv
// Round-robin arbiter feeding mux_4_1 with a single registered output stage (no skid buffer).
// Optional per-channel saturating grant counters when RR_ARB_GRANT_CNT_EN is defined.
module rr_arb_4_1
  import rr_arb_pkg::*;
#(
  parameter int W = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  rr_arb_4_1_if.slave            bus
`ifdef RR_ARB_GRANT_CNT_EN
  ,
  output logic [N_CH*CNT_W-1:0]  grant_cnt
`endif
);
  logic              out_valid_q, out_valid_d;
  logic [W-1:0]      out_data_q,  out_data_d;
  sel_t              out_sel_q,   out_sel_d;
  sel_t              ptr_q,       ptr_d;
  sel_t              grant;
  logic              any_valid;
  logic              can_accept;
  logic              transfer;
  logic [W-1:0]      mux_y;

  // Search starts one past the last winner; off=4 wraps back onto ptr itself.
  always_comb begin
    grant     = ptr_q;
    any_valid = 1'b0;
    for (int off = 1; off <= N_CH; off++) begin
      sel_t idx;
      idx = ptr_q + off[SEL_W-1:0];
      if (!any_valid && bus.in_valid[idx]) begin
        grant     = idx;
        any_valid = 1'b1;
      end
    end
  end

  assign can_accept = !out_valid_q || bus.out_ready;
  assign transfer   = can_accept && any_valid;

  always_comb begin
    bus.in_ready = '0;
    if (transfer) bus.in_ready[grant] = 1'b1;
  end

  mux_4_1 u_mux (
    .d0  (bus.in_data[0*W +: W]),
    .d1  (bus.in_data[1*W +: W]),
    .d2  (bus.in_data[2*W +: W]),
    .d3  (bus.in_data[3*W +: W]),
    .sel (grant),
    .y   (mux_y)
  );

  always_comb begin
    out_valid_d = out_valid_q && !bus.out_ready;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    ptr_d       = ptr_q;
    if (transfer) begin
      out_valid_d = 1'b1;
      out_data_d  = mux_y;
      out_sel_d   = grant;
      ptr_d       = grant;
    end
  end

  // ptr resets to 3 so channel 0 is searched first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      ptr_q       <= sel_t'(N_CH - 1);
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      ptr_q       <= ptr_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;

`ifdef RR_ARB_GRANT_CNT_EN
  logic [CNT_W-1:0] cnt_q [N_CH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) cnt_q[i] <= '0;
    end else if (transfer && (cnt_q[grant] != {CNT_W{1'b1}})) begin
      cnt_q[grant] <= cnt_q[grant] + 1'b1;
    end
  end

  always_comb begin
    grant_cnt = '0;
    for (int i = 0; i < N_CH; i++) grant_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
  end
`endif
endmodule : rr_arb_4_1

// File: tb/tb_rr_arb_4_1.sv
// Bench for rr_arb_4_1: directed scenarios plus random traffic against a queue-based reference model.
module tb_rr_arb_4_1;
  import rr_arb_pkg::*;
  localparam int W = 4;

  logic clk;
  logic rst_n;
  rr_arb_4_1_if #(.W(W)) bus ();
`ifdef RR_ARB_GRANT_CNT_EN
  logic [N_CH*CNT_W-1:0] grant_cnt;
`endif

  rr_arb_4_1 #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef RR_ARB_GRANT_CNT_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  // reference model state
  logic [W+1:0] exp_q[$];      // {sel, data} of the word expected in the output register
  int           m_ptr;
  logic [W+1:0] m_last;
  int           m_cnt [N_CH];
  logic [3:0]   obs_ready;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_ptr  = 3;
    m_last = '0;
    for (int i = 0; i < N_CH; i++) m_cnt[i] = 0;
  endtask

  // Drive one cycle of inputs, compare against the model, then advance the model past the next edge.
  task automatic step(input logic [3:0] iv, input logic [4*W-1:0] id, input logic ordy);
    int  g;
    bit  can;
    logic [3:0] exp_ready;
    @(negedge clk);
    bus.in_valid  = iv;
    bus.in_data   = id;
    bus.out_ready = ordy;
    #1;
    can = (exp_q.size() == 0) || ordy;
    g   = -1;
    for (int k = 1; k <= N_CH; k++) begin
      int c;
      c = (m_ptr + k) % N_CH;
      if (g < 0 && iv[c]) g = c;
    end
    exp_ready = (can && g >= 0) ? 4'(1 << g) : 4'b0000;
    obs_ready = bus.in_ready;
    check_val("in_ready",  32'(bus.in_ready),  32'(exp_ready));
    check_val("out_valid", 32'(bus.out_valid), 32'(exp_q.size() > 0));
    check_val("out_data",  32'(bus.out_data),  32'(m_last[W-1:0]));
    check_val("out_sel",   32'(bus.out_sel),   32'(m_last[W+1:W]));
    if (exp_q.size() > 0 && ordy) void'(exp_q.pop_front());
    if (can && g >= 0) begin
      m_last = {2'(g), id[g*W +: W]};
      exp_q.push_back(m_last);
      m_ptr = g;
      if (m_cnt[g] < 255) m_cnt[g]++;
    end
  endtask

  task automatic do_reset();
    bus.in_valid  = '0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int rot_sel [5] = '{0, 1, 2, 3, 0};
  logic [3:0] rot_dat [5] = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hA};

  initial begin
    rst_n = 1'b1;
    bus.in_valid = '0; bus.in_data = '0; bus.out_ready = 1'b0;
    #3;
    do_reset();

    // reset values
    #1;
    check_val("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_val("rst_out_sel",   32'(bus.out_sel),   32'd0);
    check_val("rst_out_data",  32'(bus.out_data),  32'd0);
    check_val("rst_in_ready",  32'(bus.in_ready),  32'd0);

    // rotation with all channels requesting
    step(4'b1111, 16'hDCBA, 1'b1);
    check_val("first_grant", 32'(obs_ready), 32'b0001);
    for (int i = 0; i < 5; i++) begin
      step(4'b1111, 16'hDCBA, 1'b1);
      check_val("rot_sel",  32'(bus.out_sel),  32'(rot_sel[i]));
      check_val("rot_data", 32'(bus.out_data), 32'(rot_dat[i]));
    end

    // sparse requests on channels 0 and 2
    for (int i = 0; i < 6; i++) begin
      step(4'b0101, 16'h4321, 1'b1);
      check_val("sparse_no13", 32'(obs_ready & 4'b1010), 32'd0);
    end

    // backpressure: hold out_ready low for 3 cycles
    step(4'b1111, 16'h9876, 1'b1);
    for (int i = 0; i < 3; i++) step(4'b1111, 16'h9876, 1'b0);
    check_val("bp_in_ready", 32'(obs_ready), 32'd0);
    for (int i = 0; i < 4; i++) step(4'b1111, 16'h9876, 1'b1);

    // idle drain: one transfer of 7 then nothing
    step(4'b0010, 16'h0070, 1'b1);
    step(4'b0000, 16'h0000, 1'b1);
    step(4'b0000, 16'h0000, 1'b1);
    check_val("drain_valid", 32'(bus.out_valid), 32'd0);
    check_val("drain_data",  32'(bus.out_data),  32'h7);

    // async reset mid-stream
    step(4'b1111, 16'h5555, 1'b0);
    @(negedge clk);
    bus.in_valid = '0;
    #1;
    check_val("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check_val("async_rst_valid", 32'(bus.out_valid), 32'd0);
    check_val("async_rst_data",  32'(bus.out_data),  32'd0);
    check_val("async_rst_sel",   32'(bus.out_sel),   32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(4'b1010, 16'h3210, 1'b1);
    check_val("post_rst_grant", 32'(obs_ready), 32'b0010);
    step(4'b0000, 16'h0000, 1'b1);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      step(4'($urandom_range(0, 15)), 16'($urandom), ($urandom_range(0, 3) != 0));
    end

`ifdef RR_ARB_GRANT_CNT_EN
    do_reset();
    for (int i = 0; i < 300; i++) step(4'b0100, 16'($urandom), 1'b1);
    step(4'b0000, 16'h0000, 1'b1);
    for (int i = 0; i < N_CH; i++)
      check_val("grant_cnt", 32'(grant_cnt[i*CNT_W +: CNT_W]), 32'(m_cnt[i]));
    check_val("grant_cnt2_sat", 32'(grant_cnt[2*CNT_W +: CNT_W]), 32'hFF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule : tb_rr_arb_4_1
